// File: rtl/neopixel_frame_arbiter_if.sv
// Bundle between the two pattern producers, the NeoPixel driver and the arbiter.
// The arbiter takes the slave view; the producers and the driver take the master view.
interface neopixel_frame_arbiter_if;
  // Producer side: client i owns bit i, or the slice at i * width.
  logic [1:0]  c_req;
  logic [1:0]  c_load_color;
  logic [5:0]  c_pixel_index;
  logic [3:0]  c_color_index;
  logic [15:0] c_color_level;
  logic [1:0]  c_send_it;
  logic [1:0]  c_gnt;
  logic [1:0]  c_ready_to_load;
  logic [1:0]  c_ready_to_send;
  logic [1:0]  c_done;

  // Driver side.
  logic        ready_to_load;
  logic        ready_to_send;
  logic        done_wait;
  logic [2:0]  pixel_index;
  logic [1:0]  color_index;
  logic [7:0]  color_level;
  logic        load_color;
  logic        send_it;

  modport master (
    output c_req, c_load_color, c_pixel_index, c_color_index, c_color_level, c_send_it,
    output ready_to_load, ready_to_send, done_wait,
    input  c_gnt, c_ready_to_load, c_ready_to_send, c_done,
    input  pixel_index, color_index, color_level, load_color, send_it
  );

  modport slave (
    input  c_req, c_load_color, c_pixel_index, c_color_index, c_color_level, c_send_it,
    input  ready_to_load, ready_to_send, done_wait,
    output c_gnt, c_ready_to_load, c_ready_to_send, c_done,
    output pixel_index, color_index, color_level, load_color, send_it
  );
endinterface

// File: rtl/neopixel_frame_arbiter.sv
// Round-robin whole-frame arbiter sharing one NeoPixel driver between two producers,
// with a watchdog that reclaims the driver from an owner that never sends.
module neopixel_frame_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF,
  parameter int unsigned FCNT_W         = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  neopixel_frame_arbiter_if.slave bus,
  output logic                 timeout,
  output logic [FCNT_W-1:0]    frame_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE} state_t;

  state_t          state, state_next;
  logic            owner, owner_next;
  logic            last_owner, last_owner_next;
  logic [WD_W-1:0] watchdog, watchdog_next;
  logic [1:0]      gnt_next, done_next;
  logic            timeout_next;
  logic            count_en;

  logic [1:0] owner_hot;
  logic       own_req, own_load, own_send, expired;

  assign owner_hot = owner ? 2'b10 : 2'b01;
  assign own_req   = bus.c_req[owner];
  assign own_load  = bus.c_load_color[owner];
  assign own_send  = bus.c_send_it[owner];
  assign expired   = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no path leaves a latch.
    state_next          = state;
    owner_next          = owner;
    last_owner_next     = last_owner;
    watchdog_next       = watchdog;
    gnt_next            = 2'b00;
    done_next           = 2'b00;
    timeout_next        = 1'b0;
    count_en            = 1'b0;
    bus.pixel_index     = '0;
    bus.color_index     = '0;
    bus.color_level     = '0;
    bus.load_color      = 1'b0;
    bus.send_it         = 1'b0;
    bus.c_ready_to_load = 2'b00;
    bus.c_ready_to_send = 2'b00;

    // While a grant is held the driver sees only the owner's slice and readiness.
    if (state != IDLE) begin
      bus.pixel_index     = owner ? bus.c_pixel_index[5:3]  : bus.c_pixel_index[2:0];
      bus.color_index     = owner ? bus.c_color_index[3:2]  : bus.c_color_index[1:0];
      bus.color_level     = owner ? bus.c_color_level[15:8] : bus.c_color_level[7:0];
      bus.c_ready_to_load = owner_hot & {2{bus.ready_to_load}};
      bus.c_ready_to_send = owner_hot & {2{bus.ready_to_send}};
    end

    case (state)
      IDLE: begin
        if (|bus.c_req) begin
          owner_next    = (bus.c_req == 2'b11) ? ~last_owner : bus.c_req[1];
          gnt_next      = owner_next ? 2'b10 : 2'b01;
          watchdog_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        gnt_next       = owner_hot;
        bus.load_color = own_load & bus.ready_to_load;
        watchdog_next  = watchdog + WD_W'(1);
        // A send wins over a simultaneous request drop or watchdog expiry.
        if (own_send && bus.ready_to_send) begin
          bus.send_it    = 1'b1;
          bus.load_color = 1'b0;
          watchdog_next  = '0;
          state_next     = WAIT_DONE;
        end else if (!own_req) begin
          gnt_next        = 2'b00;
          last_owner_next = owner;
          watchdog_next   = '0;
          state_next      = IDLE;
        end else if (expired) begin
          gnt_next        = 2'b00;
          timeout_next    = 1'b1;
          last_owner_next = owner;
          watchdog_next   = '0;
          state_next      = IDLE;
        end
      end
      WAIT_DONE: begin
        gnt_next = owner_hot;
        if (bus.done_wait) begin
          gnt_next        = 2'b00;
          done_next       = owner_hot;
          count_en        = 1'b1;
          last_owner_next = owner;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      watchdog    <= '0;
      frame_count <= '0;
      timeout     <= 1'b0;
      bus.c_gnt   <= 2'b00;
      bus.c_done  <= 2'b00;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      last_owner  <= last_owner_next;
      watchdog    <= watchdog_next;
      frame_count <= frame_count + FCNT_W'(count_en);
      timeout     <= timeout_next;
      bus.c_gnt   <= gnt_next;
      bus.c_done  <= done_next;
    end
  end
endmodule

// File: tb/tb_neopixel_frame_arbiter.sv
// Randomized scoreboard bench: stimulus predicts grant/load/send/done/timeout events
// with cycle stamps; a negedge monitor pops and compares whatever the arbiter presents.
module tb_neopixel_frame_arbiter;
  localparam int TIMEOUT = 8;
  localparam int FCNT_W  = 16;

  typedef enum logic [7:0] {EV_RELEASE, EV_GRANT, EV_LOAD, EV_SEND, EV_DONE, EV_TIMEOUT} ev_t;
  typedef struct packed {
    ev_t         kind;
    logic [15:0] cyc;
    logic [7:0]  vec;
    logic [31:0] data;
  } ev_s;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              timeout;
  logic [FCNT_W-1:0] frame_count;

  neopixel_frame_arbiter_if bus();

  neopixel_frame_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .FCNT_W(FCNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .timeout     (timeout),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ev_s  exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: who asks, who owned last, how many frames finished.
  logic [1:0] req = 2'b00;
  int         last = 1;
  int         count = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] oh(input int o);
    return (o != 0) ? 8'h02 : 8'h01;
  endfunction

  function automatic int pick();
    if (req == 2'b11) return 1 - last;
    return (req == 2'b10) ? 1 : 0;
  endfunction

  task automatic expect_ev(input ev_t k, input int c, input logic [7:0] v, input logic [31:0] d);
    ev_s e;
    e.kind = k; e.cyc = 16'(c); e.vec = v; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_t k, input logic [7:0] v, input logic [31:0] d);
    ev_s o, e;
    o.kind = k; o.cyc = 16'(cyc); o.vec = v; o.data = d;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_%s: got %h required no event (t=%0t)", k.name(), o, $time);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_%s", e.kind.name()), o, e);
    end
  endtask

  // Monitor: samples away from the active edge, in a fixed per-cycle event order.
  logic [1:0] prev_gnt = 2'b00;
  always @(negedge clock) begin
    if (reset) begin
      prev_gnt = 2'b00;
    end else begin
      if (bus.c_gnt != prev_gnt) begin
        if (prev_gnt != 2'b00) observe(EV_RELEASE, {6'b0, prev_gnt}, 32'd0);
        if (bus.c_gnt != 2'b00) observe(EV_GRANT, {6'b0, bus.c_gnt}, 32'd0);
      end
      prev_gnt = bus.c_gnt;
      if (bus.load_color)
        observe(EV_LOAD, {6'b0, bus.c_ready_to_load},
                {19'b0, bus.pixel_index, bus.color_index, bus.color_level});
      if (bus.send_it)         observe(EV_SEND, {6'b0, bus.c_ready_to_send}, 32'd0);
      if (bus.c_done != 2'b00) observe(EV_DONE, {6'b0, bus.c_done}, 32'(frame_count));
      if (timeout)             observe(EV_TIMEOUT, {6'b0, bus.c_gnt}, 32'(frame_count));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Random data everywhere, random strobes on the non-owner; owner strobes cleared.
  task automatic noise(input int o);
    bus.c_pixel_index = 6'($urandom);
    bus.c_color_index = 4'($urandom);
    bus.c_color_level = 16'($urandom);
    bus.c_load_color  = 2'($urandom);
    bus.c_send_it     = 2'($urandom);
    if (o >= 0) begin
      bus.c_load_color[o] = 1'b0;
      bus.c_send_it[o]    = 1'b0;
    end
    bus.ready_to_load = 1'($urandom);
    bus.ready_to_send = 1'($urandom);
    bus.done_wait     = 1'b0;
  endtask

  task automatic grant_cycle(input int o, input bit expire);
    logic [2:0] p;
    logic [1:0] c;
    logic [7:0] l;
    bit ld, rl;
    noise(o);
    p = 3'($urandom); c = 2'($urandom); l = 8'($urandom);
    ld = ($urandom_range(0, 3) != 0);
    rl = 1'($urandom);
    bus.c_pixel_index[3*o +: 3] = p;
    bus.c_color_index[2*o +: 2] = c;
    bus.c_color_level[8*o +: 8] = l;
    bus.c_load_color[o] = ld;
    bus.ready_to_load   = rl;
    if ($urandom_range(0, 3) == 0) begin
      bus.c_send_it[o]  = 1'b1;
      bus.ready_to_send = 1'b0;
    end
    if (ld && rl) expect_ev(EV_LOAD, cyc, oh(o), {19'b0, p, c, l});
    if (expire) begin
      expect_ev(EV_RELEASE, cyc + 1, oh(o), 32'd0);
      expect_ev(EV_TIMEOUT, cyc + 1, 8'd0, 32'(count % 65536));
    end
    step();
  endtask

  task automatic send_cycle(input int o);
    noise(o);
    bus.c_load_color[o] = 1'b1;
    bus.ready_to_load   = 1'b1;
    bus.c_send_it[o]    = 1'b1;
    bus.ready_to_send   = 1'b1;
    expect_ev(EV_SEND, cyc, oh(o), 32'd0);
    step();
  endtask

  task automatic finish_frame(input int o);
    repeat ($urandom_range(0, 4)) begin
      noise(o);
      bus.c_load_color[o] = 1'b1;
      bus.ready_to_load   = 1'b1;
      bus.c_send_it[o]    = 1'b1;
      bus.ready_to_send   = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        req[o]    = 1'b0;
        bus.c_req = req;
      end
      step();
    end
    noise(o);
    bus.done_wait = 1'b1;
    count++;
    expect_ev(EV_RELEASE, cyc + 1, oh(o), 32'd0);
    expect_ev(EV_DONE, cyc + 1, oh(o), 32'(count % 65536));
    step();
    req[o]    = 1'b0;
    bus.c_req = req;
    last      = o;
  endtask

  // Mode 0 normal frame, 1 watchdog timeout, 2 send on the expiry cycle, 3 request drop.
  task automatic run_frame(input int mode, input bit both);
    int o;
    noise(-1);
    if (both) req = 2'b11;
    else begin
      req |= 2'($urandom_range(0, 3));
      if (req == 2'b00) req = 2'($urandom_range(1, 3));
    end
    bus.c_req = req;
    o = pick();
    expect_ev(EV_GRANT, cyc + 1, oh(o), 32'd0);
    step();
    case (mode)
      1: begin
        for (int i = 0; i < TIMEOUT - 1; i++) grant_cycle(o, 1'b0);
        grant_cycle(o, 1'b1);
        last = o;
        if ($urandom_range(0, 1) == 0) req[o] = 1'b0;
        bus.c_req = req;
      end
      2: begin
        for (int i = 0; i < TIMEOUT - 1; i++) grant_cycle(o, 1'b0);
        send_cycle(o);
        finish_frame(o);
      end
      3: begin
        repeat ($urandom_range(0, TIMEOUT - 2)) grant_cycle(o, 1'b0);
        noise(o);
        req[o]    = 1'b0;
        bus.c_req = req;
        expect_ev(EV_RELEASE, cyc + 1, oh(o), 32'd0);
        step();
        last = o;
      end
      default: begin
        repeat ($urandom_range(0, 5)) grant_cycle(o, 1'b0);
        send_cycle(o);
        finish_frame(o);
      end
    endcase
  endtask

  initial begin
    int o;
    bus.c_req = 2'b00;
    noise(-1);
    #1;
    check("reset_gnt",         64'(bus.c_gnt),       64'd0);
    check("reset_done",        64'(bus.c_done),      64'd0);
    check("reset_timeout",     64'(timeout),         64'd0);
    check("reset_frame_count", 64'(frame_count),     64'd0);
    check("reset_drv_load",    64'(bus.load_color),  64'd0);
    check("reset_drv_send",    64'(bus.send_it),     64'd0);
    check("reset_drv_pixel",   64'({bus.pixel_index, bus.color_index, bus.color_level}), 64'd0);
    repeat (3) step();
    reset = 1'b0;

    // Client 0 alone: grant one cycle later, then a known colour load.
    noise(-1);
    req = 2'b01;
    bus.c_req = req;
    expect_ev(EV_GRANT, cyc + 1, oh(0), 32'd0);
    step();
    noise(0);
    bus.c_load_color[0]     = 1'b1;
    bus.ready_to_load       = 1'b1;
    bus.c_pixel_index[2:0]  = 3'd2;
    bus.c_color_index[1:0]  = 2'd1;
    bus.c_color_level[7:0]  = 8'h1F;
    expect_ev(EV_LOAD, cyc, oh(0), {19'b0, 3'd2, 2'd1, 8'h1F});
    step();
    noise(0);
    bus.c_load_color[0] = 1'b1;
    bus.ready_to_load   = 1'b0;
    step();
    send_cycle(0);
    finish_frame(0);

    // Both always requesting: ownership alternates.
    repeat (4) run_frame(0, 1'b1);
    run_frame(1, 1'b1);
    run_frame(2, 1'b1);
    run_frame(1, 1'b0);
    repeat (30) run_frame(int'($urandom_range(0, 3)), 1'b0);

    // Reset in the middle of WAIT_DONE abandons the frame at once.
    noise(-1);
    req |= 2'b01;
    bus.c_req = req;
    o = pick();
    expect_ev(EV_GRANT, cyc + 1, oh(o), 32'd0);
    step();
    send_cycle(o);
    noise(o);
    bus.c_load_color[o] = 1'b1;
    bus.ready_to_load   = 1'b1;
    bus.c_send_it[o]    = 1'b1;
    bus.ready_to_send   = 1'b1;
    reset = 1'b1;
    #1;
    check("midreset_gnt",         64'(bus.c_gnt),      64'd0);
    check("midreset_send",        64'(bus.send_it),    64'd0);
    check("midreset_load",        64'(bus.load_color), 64'd0);
    check("midreset_frame_count", 64'(frame_count),    64'd0);
    req = 2'b00;
    bus.c_req = req;
    step();
    step();
    reset = 1'b0;
    count = 0;
    last  = 1;
    run_frame(0, 1'b1);
    run_frame(0, 1'b1);

    req = 2'b00;
    bus.c_req = req;
    repeat (4) begin
      noise(-1);
      step();
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
